// File: rtl/barrel_shifter_32_if.sv
// -----------------------------------------------------------------------------
// barrel_shifter_32_if
// Operation/result bundle for barrel_shifter_32.
//
// Signals:
//   in_valid  requester -> shifter  qualifies i/s/is_left/is_sra this cycle
//   i[31:0]   requester -> shifter  data to shift
//   s[4:0]    requester -> shifter  unsigned shift amount, 0..31
//   is_left   requester -> shifter  1 = logical left shift
//   is_sra    requester -> shifter  right shifts only: 1 = arithmetic, 0 = logical
//   o[31:0]   shifter -> requester  registered shift result
//   out_valid shifter -> requester  o holds a new result this cycle
//
// Modports:
//   master  the side issuing operations (testbench / upstream logic)
//   slave   the shifter itself
// -----------------------------------------------------------------------------
interface barrel_shifter_32_if;
  logic        in_valid;
  logic [31:0] i;
  logic [4:0]  s;
  logic        is_left;
  logic        is_sra;
  logic [31:0] o;
  logic        out_valid;

  modport master (
    output in_valid, i, s, is_left, is_sra,
    input  o, out_valid
  );

  modport slave (
    input  in_valid, i, s, is_left, is_sra,
    output o, out_valid
  );
endinterface : barrel_shifter_32_if

// File: rtl/barrel_shifter_32.sv
// -----------------------------------------------------------------------------
// barrel_shifter_32
// 32-bit barrel shifter supporting logical left, logical right and arithmetic
// right shifts by 0..31 positions, with a registered result.
//
// Ports:
//   clk  input   rising-edge clock for all state
//   rst  input   synchronous, active-high reset
//   bus  slave   barrel_shifter_32_if (in_valid, i, s, is_left, is_sra -> o,
//                out_valid)
//
// Datapath:
//   A single right-shift datapath of five cascaded mux stages (16, 8, 4, 2, 1
//   positions, enabled by s[4]..s[0]). Left shifts reuse it by bit-reversing
//   the operand on the way in and the result on the way out; the fill bit is
//   forced to zero for left and logical-right shifts and is i[31] for
//   arithmetic-right shifts.
//
// Configuration:
//   BARREL_SHIFTER_32_PIPE_EN  when defined, a register stage (data, fill bit,
//   direction, remaining shift bits, valid) sits after the 8-bit stage and the
//   latency becomes 2 cycles. When undefined, everything up to the output
//   register is combinational and the latency is 1 cycle. Results are
//   identical in both builds.
//
// Timing:
//   One operation accepted every cycle, no backpressure; out_valid tracks
//   in_valid with the same latency as o. o only changes when a valid
//   operation completes, otherwise it holds.
// -----------------------------------------------------------------------------
module barrel_shifter_32 (
  input  logic               clk,
  input  logic               rst,
  barrel_shifter_32_if.slave bus
);

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] bit_reverse(input logic [31:0] d);
    logic [31:0] r;
    for (int k = 0; k < 32; k++) begin
      r[k] = d[31-k];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Front end: operand conditioning and the 16/8-position stages
  // ---------------------------------------------------------------------------
  logic [31:0] src;
  logic        fill;
  logic [31:0] st16;
  logic [31:0] st8;

  // Left shifts run through the right-shift datapath on a mirrored operand.
  assign src  = bus.is_left ? bit_reverse(bus.i) : bus.i;

  // Only arithmetic right shifts replicate the sign; everything else zero-fills.
  assign fill = ~bus.is_left & bus.is_sra & bus.i[31];

  assign st16 = bus.s[4] ? {{16{fill}}, src[31:16]} : src;
  assign st8  = bus.s[3] ? {{8{fill}},  st16[31:8]} : st16;

  // ---------------------------------------------------------------------------
  // Optional mid-datapath register
  // ---------------------------------------------------------------------------
  logic [31:0] mid_data;
  logic        mid_fill;
  logic        mid_left;
  logic [2:0]  mid_s;
  logic        mid_valid;

`ifdef BARREL_SHIFTER_32_PIPE_EN
  logic [31:0] pipe_data_q;
  logic        pipe_fill_q;
  logic        pipe_left_q;
  logic [2:0]  pipe_s_q;
  logic        pipe_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_data_q  <= '0;
      pipe_fill_q  <= 1'b0;
      pipe_left_q  <= 1'b0;
      pipe_s_q     <= '0;
      pipe_valid_q <= 1'b0;
    end else begin
      pipe_valid_q <= bus.in_valid;
      // Payload only moves with a valid operation, so idle cycles do not
      // toggle the wide register.
      if (bus.in_valid) begin
        pipe_data_q <= st8;
        pipe_fill_q <= fill;
        pipe_left_q <= bus.is_left;
        pipe_s_q    <= bus.s[2:0];
      end
    end
  end

  assign mid_data  = pipe_data_q;
  assign mid_fill  = pipe_fill_q;
  assign mid_left  = pipe_left_q;
  assign mid_s     = pipe_s_q;
  assign mid_valid = pipe_valid_q;
`else
  assign mid_data  = st8;
  assign mid_fill  = fill;
  assign mid_left  = bus.is_left;
  assign mid_s     = bus.s[2:0];
  assign mid_valid = bus.in_valid;
`endif

  // ---------------------------------------------------------------------------
  // Back end: 4/2/1-position stages and output un-mirroring
  // ---------------------------------------------------------------------------
  logic [31:0] st4;
  logic [31:0] st2;
  logic [31:0] st1;
  logic [31:0] o_d;

  assign st4 = mid_s[2] ? {{4{mid_fill}}, mid_data[31:4]} : mid_data;
  assign st2 = mid_s[1] ? {{2{mid_fill}}, st4[31:2]}      : st4;
  assign st1 = mid_s[0] ? {mid_fill,      st2[31:1]}      : st2;

  assign o_d = mid_left ? bit_reverse(st1) : st1;

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  logic [31:0] o_q;
  logic        out_valid_q;

  // NOTE: state is written with non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= mid_valid;
      if (mid_valid) begin
        o_q <= o_d;
      end
    end
  end

  assign bus.o         = o_q;
  assign bus.out_valid = out_valid_q;

endmodule : barrel_shifter_32

// File: tb/tb_barrel_shifter_32.sv
// -----------------------------------------------------------------------------
// tb_barrel_shifter_32
// Directed self-checking bench for barrel_shifter_32. Expected results are
// hand-computed constants. Inputs are driven and outputs sampled 1 time unit
// after each rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_barrel_shifter_32;

`ifdef BARREL_SHIFTER_32_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst;

  barrel_shifter_32_if bus ();

  barrel_shifter_32 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] din, input logic [4:0] sh,
                       input logic left, input logic sra);
    bus.in_valid = v;
    bus.i        = din;
    bus.s        = sh;
    bus.is_left  = left;
    bus.is_sra   = sra;
  endtask

  // Issue a single operation, idle afterwards, and check the result one
  // latency later.
  task automatic run_op(input string tag, input logic [31:0] din, input logic [4:0] sh,
                        input logic left, input logic sra, input logic [31:0] exp);
    drive(1'b1, din, sh, left, sra);
    step();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    for (int k = 1; k < LAT; k++) begin
      check({tag, "_early_valid"}, {31'b0, bus.out_valid}, 32'd0);
      step();
    end
    check(tag, bus.o, exp);
    check({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
  endtask

  typedef struct {
    string       tag;
    logic [31:0] din;
    logic [4:0]  sh;
    logic        left;
    logic        sra;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  vec_t b2b[4];

  initial begin
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    step();
    check("reset_o", bus.o, 32'h0);
    check("reset_valid", {31'b0, bus.out_valid}, 32'd0);
    rst = 1'b0;

    // Idle after reset: nothing appears.
    step();
    check("idle_valid", {31'b0, bus.out_valid}, 32'd0);

    vecs = '{
      '{"sll_1_4",        32'h00000001, 5'd4,  1'b1, 1'b0, 32'h00000010},
      '{"srl_f0_4",       32'hF0000000, 5'd4,  1'b0, 1'b0, 32'h0F000000},
      '{"sra_f0_4",       32'hF0000000, 5'd4,  1'b0, 1'b1, 32'hFF000000},
      '{"sra_70_4",       32'h70000000, 5'd4,  1'b0, 1'b1, 32'h07000000},
      '{"srl_ones_31",    32'hFFFFFFFF, 5'd31, 1'b0, 1'b0, 32'h00000001},
      '{"sll_ones_31",    32'hFFFFFFFF, 5'd31, 1'b1, 1'b0, 32'h80000000},
      '{"sra_ones_31",    32'hFFFFFFFF, 5'd31, 1'b0, 1'b1, 32'hFFFFFFFF},
      '{"sll_s0",         32'h12345678, 5'd0,  1'b1, 1'b0, 32'h12345678},
      '{"srl_s0",         32'h12345678, 5'd0,  1'b0, 1'b0, 32'h12345678},
      '{"sra_s0",         32'h87654321, 5'd0,  1'b0, 1'b1, 32'h87654321},
      '{"sll_16",         32'h12345678, 5'd16, 1'b1, 1'b0, 32'h56780000},
      '{"srl_8",          32'h12345678, 5'd8,  1'b0, 1'b0, 32'h00123456},
      '{"sra_12",         32'h87654321, 5'd12, 1'b0, 1'b1, 32'hFFF87654},
      '{"srl_20",         32'hDEADBEEF, 5'd20, 1'b0, 1'b0, 32'h00000DEA},
      '{"sll_2",          32'hDEADBEEF, 5'd2,  1'b1, 1'b0, 32'h7AB6FBBC},
      '{"sll_ignore_sra", 32'h0000000F, 5'd28, 1'b1, 1'b1, 32'hF0000000},
      '{"sra_pos_30",     32'h40000000, 5'd30, 1'b0, 1'b1, 32'h00000001},
      '{"sll_one_31",     32'h00000001, 5'd31, 1'b1, 1'b0, 32'h80000000},
      '{"srl_msb_31",     32'h80000000, 5'd31, 1'b0, 1'b0, 32'h00000001},
      '{"sra_1",          32'h80000001, 5'd1,  1'b0, 1'b1, 32'hC0000000},
      '{"srl_1",          32'h80000001, 5'd1,  1'b0, 1'b0, 32'h40000000},
      '{"sll_1",          32'h80000001, 5'd1,  1'b1, 1'b0, 32'h00000002},
      '{"sra_5",          32'h80000000, 5'd5,  1'b0, 1'b1, 32'hFC000000},
      '{"srl_7",          32'hFFFFFFFF, 5'd7,  1'b0, 1'b0, 32'h01FFFFFF},
      '{"sll_3",          32'h0000000F, 5'd3,  1'b1, 1'b0, 32'h00000078},
      '{"sra_24",         32'h81234567, 5'd24, 1'b0, 1'b1, 32'hFFFFFF81}
    };
    foreach (vecs[n]) begin
      run_op(vecs[n].tag, vecs[n].din, vecs[n].sh, vecs[n].left, vecs[n].sra, vecs[n].exp);
    end

    // o holds its value once in_valid has dropped.
    step();
    check("hold_valid", {31'b0, bus.out_valid}, 32'd0);
    check("hold_o", bus.o, 32'hFFFFFF81);

    // Back-to-back throughput: four consecutive operations, results in order.
    b2b[0] = '{"b2b0", 32'h00000003, 5'd1,  1'b1, 1'b0, 32'h00000006};
    b2b[1] = '{"b2b1", 32'hA0000000, 5'd2,  1'b0, 1'b1, 32'hE8000000};
    b2b[2] = '{"b2b2", 32'hA0000000, 5'd2,  1'b0, 1'b0, 32'h28000000};
    b2b[3] = '{"b2b3", 32'h0000FFFF, 5'd8,  1'b1, 1'b0, 32'h00FFFF00};
    for (int c = 0; c < 4 + LAT - 1; c++) begin
      if (c < 4) drive(1'b1, b2b[c].din, b2b[c].sh, b2b[c].left, b2b[c].sra);
      else       drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
      step();
      if (c - (LAT - 1) >= 0) begin
        check(b2b[c - (LAT - 1)].tag, bus.o, b2b[c - (LAT - 1)].exp);
        check({b2b[c - (LAT - 1)].tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
      end
    end

    // Reset mid-stream: an op in flight and an op coincident with reset are
    // both discarded.
    drive(1'b1, 32'h00000001, 5'd8, 1'b1, 1'b0);
    step();
    rst = 1'b1;
    drive(1'b1, 32'h00000001, 5'd9, 1'b1, 1'b0);
    step();
    check("midrst_o", bus.o, 32'h0);
    check("midrst_valid", {31'b0, bus.out_valid}, 32'd0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    for (int k = 0; k < LAT + 1; k++) begin
      step();
      check("postrst_valid", {31'b0, bus.out_valid}, 32'd0);
      check("postrst_o", bus.o, 32'h0);
    end

    // First result after reset release appears exactly one latency later.
    run_op("first_after_rst", 32'h0000ABCD, 5'd4, 1'b1, 1'b0, 32'h000ABCD0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_barrel_shifter_32
